reg_bank: RTL and testbench

- Parametrised multi-register bank for the 8-bit CPU datapath. It is the successor to the single bus-loaded register.
- Holds DEPTH registers of WIDTH bits each.
- Loads any register from the shared bus and drives any register onto the bus under output enable.
- Feeds two operand ports to the ALU.
- Executes in-place ops (inc/dec/clear/shift/swap) through a valid/ready handshake, with a two-cycle swap state machine and registered status flags.

---
 rtl/reg_bank.sv | 226 ++++++++++++++++++++++
 tb/tb_reg_bank.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: a bank of DEPTH registers, each WIDTH bits wide, for the 8-bit CPU datapath.
// A register is loaded from the shared bus or modified in place (inc/dec/clr/shl/shr).
// A register can be driven back onto the bus under output enable.
// Two combinational operand ports feed the ALU.
// SWAP needs two writes but the bank has one write port, so SWAP runs as IDLE -> SWAP2 -> IDLE.
// The original destination value is parked in a temp register between the two steps.
// Selects at or above DEPTH address nothing: their writes vanish and their reads return zero.
module reg_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [ADDR_W-1:0] dst_sel,
    input  logic [ADDR_W-1:0] src_sel,
    input  logic [WIDTH-1:0]  bus_in,
    input  logic              out_en,
    input  logic [ADDR_W-1:0] out_sel,
    output logic [WIDTH-1:0]  bus_out,
    output logic              bus_drive,
    input  logic [ADDR_W-1:0] a_sel,
    input  logic [ADDR_W-1:0] b_sel,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic              op_done,
    output logic              zero_flag,
    output logic              carry_flag
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_SWAP = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWAP2 = 1'b1;

    logic [WIDTH-1:0]  r_regs [DEPTH];
    logic [WIDTH-1:0]  r_temp;
    logic [ADDR_W-1:0] r_swapSrc;
    logic [0:0]        r_state;
    logic              r_opDone;
    logic              r_zero;
    logic              r_carry;

    logic              w_opReady;
    logic              w_accept;
    logic              w_isSwap;
    logic              w_isModify;
    logic              w_dstOk;
    logic [WIDTH-1:0]  w_dstVal;
    logic [WIDTH-1:0]  w_srcVal;
    logic [WIDTH-1:0]  w_result;
    logic              w_carryNext;

    // Mux one register out of the bank; selects past the last register read as zero.
    function automatic logic [WIDTH-1:0] readReg(input logic [WIDTH-1:0] regs [DEPTH],
                                                 input logic [ADDR_W-1:0] sel);
        logic [WIDTH-1:0] value;
        value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel == ADDR_W'(i)) begin
                value = regs[i];
            end
        end
        return value;
    endfunction

    // True when the select addresses a register that physically exists.
    function automatic logic inRange(input logic [ADDR_W-1:0] sel);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel == ADDR_W'(i)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Handshake decode: requests are taken only while idle.
    // A SWAP is split from the single-cycle ops that write one register and update flags.
    always_comb begin
        w_opReady  = (r_state == S_IDLE);
        w_accept   = op_valid && w_opReady;
        w_isSwap   = (op_code == OP_SWAP);
        w_isModify = (op_code != OP_NOP) && (op_code != OP_SWAP);
        w_dstOk    = inRange(dst_sel);
        w_dstVal   = readReg(r_regs, dst_sel);
        w_srcVal   = readReg(r_regs, src_sel);
    end

    // Compute the value a single-cycle op writes back.
    // Also compute the carry it reports: the wrap, the borrow or the bit shifted out.
    always_comb begin
        w_result    = w_dstVal;
        w_carryNext = 1'b0;
        case (op_code)
            OP_LOAD: begin
                w_result    = bus_in;
                w_carryNext = 1'b0;
            end
            OP_INC: begin
                {w_carryNext, w_result} = {1'b0, w_dstVal} + {{WIDTH{1'b0}}, 1'b1};
            end
            OP_DEC: begin
                w_result    = w_dstVal - WIDTH'(1);
                w_carryNext = (w_dstVal == '0);
            end
            OP_CLR: begin
                w_result    = '0;
                w_carryNext = 1'b0;
            end
            OP_SHL: begin
                w_result    = {w_dstVal[WIDTH-2:0], 1'b0};
                w_carryNext = w_dstVal[WIDTH-1];
            end
            OP_SHR: begin
                w_result    = {1'b0, w_dstVal[WIDTH-1:1]};
                w_carryNext = w_dstVal[0];
            end
            default: begin
                w_result    = w_dstVal;
                w_carryNext = 1'b0;
            end
        endcase
    end

    // Sequence ops.
    // SWAP parks in SWAP2 for one cycle and remembers where the second write goes.
    // op_done follows the final write of every op, NOP included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_opDone  <= 1'b0;
            r_swapSrc <= '0;
        end else begin
            r_opDone <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_isSwap) begin
                            r_state   <= S_SWAP2;
                            r_swapSrc <= src_sel;
                        end else begin
                            r_opDone <= 1'b1;
                        end
                    end
                end
                S_SWAP2: begin
                    r_state  <= S_IDLE;
                    r_opDone <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Register file writes, one port per cycle.
    // The second half of a SWAP writes the parked value to the captured source.
    // Otherwise the accepted op writes its destination.
    // Selects that match no register write nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_temp <= '0;
        end else if (r_state == S_SWAP2) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_swapSrc == ADDR_W'(i)) begin
                    r_regs[i] <= r_temp;
                end
            end
        end else if (w_accept && w_isSwap) begin
            r_temp <= w_dstVal;
            for (int i = 0; i < DEPTH; i++) begin
                if (dst_sel == ADDR_W'(i)) begin
                    r_regs[i] <= w_srcVal;
                end
            end
        end else if (w_accept && w_isModify) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dst_sel == ADDR_W'(i)) begin
                    r_regs[i] <= w_result;
                end
            end
        end
    end

    // Status flags describe the last real write.
    // NOP, SWAP and writes to a missing register leave them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_accept && w_isModify && w_dstOk) begin
            r_zero  <= (w_result == '0);
            r_carry <= w_carryNext;
        end
    end

    // Read side: ALU operands and the bus driver come straight from the current contents.
    // The bus driver runs independently of any op in flight.
    always_comb begin
        alu_a      = readReg(r_regs, a_sel);
        alu_b      = readReg(r_regs, b_sel);
        bus_out    = out_en ? readReg(r_regs, out_sel) : '0;
        bus_drive  = out_en;
        op_ready   = w_opReady;
        op_done    = r_opDone;
        zero_flag  = r_zero;
        carry_flag = r_carry;
    end

endmodule

// File: tb/tb_reg_bank.sv
// Testbench for reg_bank.
// A behavioural model of the default 8-bit, 4-register bank tracks every clock edge.
// Its outputs are compared with the DUT on every falling edge.
// Directed sequences pin known literal values.
// A second instance with WIDTH=16, DEPTH=3 exercises the out-of-range select and 16-bit wrap.
module tb_reg_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [2:0] op_code = 3'd0;
    logic [1:0] dst_sel = 2'd0;
    logic [1:0] src_sel = 2'd0;
    logic [7:0] bus_in = 8'd0;
    logic       out_en = 1'b0;
    logic [1:0] out_sel = 2'd0;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic [1:0] a_sel = 2'd0;
    logic [1:0] b_sel = 2'd0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       op_done;
    logic       zero_flag;
    logic       carry_flag;

    logic        sRst = 1'b1;
    logic        sValid = 1'b0;
    logic [2:0]  sCode = 3'd0;
    logic [1:0]  sDst = 2'd0;
    logic [15:0] sBus = 16'd0;
    logic [1:0]  sASel = 2'd0;
    logic        sReady;
    logic        sDone;
    logic        sZero;
    logic        sCarry;
    logic [15:0] sAluA;
    logic [15:0] sAluB;
    logic [15:0] sBusOut;
    logic        sDrive;

    int nChecks = 0;
    int nFails  = 0;

    int mReg [4];
    bit mBusy = 1'b0;
    int mSrc = 0;
    int mTemp = 0;
    bit mDone = 1'b0;
    bit mZero = 1'b0;
    bit mCarry = 1'b0;
    bit started = 1'b0;

    reg_bank #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) u_dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .dst_sel(dst_sel), .src_sel(src_sel), .bus_in(bus_in),
        .out_en(out_en), .out_sel(out_sel), .bus_out(bus_out), .bus_drive(bus_drive),
        .a_sel(a_sel), .b_sel(b_sel), .alu_a(alu_a), .alu_b(alu_b),
        .op_done(op_done), .zero_flag(zero_flag), .carry_flag(carry_flag)
    );

    reg_bank #(.WIDTH(16), .DEPTH(3), .ADDR_W(2)) u_sweep (
        .clk(clk), .rst(sRst), .op_valid(sValid), .op_ready(sReady),
        .op_code(sCode), .dst_sel(sDst), .src_sel(2'd0), .bus_in(sBus),
        .out_en(1'b0), .out_sel(2'd0), .bus_out(sBusOut), .bus_drive(sDrive),
        .a_sel(sASel), .b_sel(2'd3), .alu_a(sAluA), .alu_b(sAluB),
        .op_done(sDone), .zero_flag(sZero), .carry_flag(sCarry)
    );

    always #5 clk = ~clk;

    // Record one comparison and report it if the DUT disagrees.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Present an op for exactly one edge (the bank must be idle).
    task automatic doOp(input logic [2:0] code, input logic [1:0] dst, input logic [1:0] src,
                        input logic [7:0] data);
        op_valid = 1'b1;
        op_code  = code;
        dst_sel  = dst;
        src_sel  = src;
        bus_in   = data;
        applyStimulus();
        op_valid = 1'b0;
    endtask

    // Reference model: registers as plain integers, SWAP as a pending second write.
    always @(posedge clk) begin
        int d, s, old, nv;
        bit c;
        if (rst) begin
            for (int i = 0; i < 4; i++) mReg[i] = 0;
            mBusy = 0; mSrc = 0; mTemp = 0; mDone = 0; mZero = 0; mCarry = 0;
            started = 1'b1;
        end else begin
            mDone = 0;
            if (mBusy) begin
                mReg[mSrc] = mTemp;
                mBusy = 0;
                mDone = 1;
            end else if (op_valid) begin
                d = int'(dst_sel);
                s = int'(src_sel);
                old = mReg[d];
                nv = old;
                c = 0;
                case (op_code)
                    3'd0: mDone = 1;
                    3'd5: begin
                        mTemp = old;
                        mReg[d] = mReg[s];
                        mSrc = s;
                        mBusy = 1;
                    end
                    default: begin
                        case (op_code)
                            3'd1: begin nv = int'(bus_in); c = 0; end
                            3'd2: begin nv = (old + 1) % 256; c = (old == 255); end
                            3'd3: begin nv = (old + 255) % 256; c = (old == 0); end
                            3'd4: begin nv = 0; c = 0; end
                            3'd6: begin nv = (old * 2) % 256; c = (old >= 128); end
                            default: begin nv = old / 2; c = (old % 2) == 1; end
                        endcase
                        mReg[d] = nv;
                        mZero = (nv == 0);
                        mCarry = c;
                        mDone = 1;
                    end
                endcase
            end
        end
    end

    // Compare every observable output against the model once per cycle.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("op_ready", 32'(op_ready), 32'(!mBusy));
            checkOutput("op_done", 32'(op_done), 32'(mDone));
            checkOutput("zero_flag", 32'(zero_flag), 32'(mZero));
            checkOutput("carry_flag", 32'(carry_flag), 32'(mCarry));
            checkOutput("alu_a", 32'(alu_a), 32'(mReg[a_sel]));
            checkOutput("alu_b", 32'(alu_b), 32'(mReg[b_sel]));
            checkOutput("bus_out", 32'(bus_out), out_en ? 32'(mReg[out_sel]) : 32'd0);
            checkOutput("bus_drive", 32'(bus_drive), 32'(out_en));
        end
    end

    initial begin
        // Reset, then load 0xA5 into r2.
        applyStimulus();
        rst = 1'b0;
        checkOutput("reset op_ready", 32'(op_ready), 32'd1);
        checkOutput("reset r0", 32'(alu_a), 32'h00);
        a_sel = 2'd2; b_sel = 2'd0;
        doOp(3'd1, 2'd2, 2'd0, 8'hA5);
        checkOutput("load r2", 32'(alu_a), 32'hA5);
        checkOutput("load other", 32'(alu_b), 32'h00);
        checkOutput("load done", 32'(op_done), 32'd1);
        checkOutput("load zero", 32'(zero_flag), 32'd0);
        checkOutput("load carry", 32'(carry_flag), 32'd0);
        applyStimulus();
        checkOutput("load done drop", 32'(op_done), 32'd0);

        // Wrap and flag behaviour on r1.
        a_sel = 2'd1;
        doOp(3'd1, 2'd1, 2'd0, 8'hFF);
        doOp(3'd2, 2'd1, 2'd0, 8'h00);
        checkOutput("inc wrap", 32'(alu_a), 32'h00);
        checkOutput("inc zero", 32'(zero_flag), 32'd1);
        checkOutput("inc carry", 32'(carry_flag), 32'd1);
        doOp(3'd3, 2'd1, 2'd0, 8'h00);
        checkOutput("dec wrap", 32'(alu_a), 32'hFF);
        checkOutput("dec zero", 32'(zero_flag), 32'd0);
        checkOutput("dec borrow", 32'(carry_flag), 32'd1);
        doOp(3'd7, 2'd1, 2'd0, 8'h00);
        checkOutput("shr value", 32'(alu_a), 32'h7F);
        checkOutput("shr carry", 32'(carry_flag), 32'd1);

        // SWAP r0/r3 with the request held for three edges.
        doOp(3'd1, 2'd0, 2'd0, 8'h11);
        doOp(3'd1, 2'd3, 2'd0, 8'h22);
        a_sel = 2'd0; b_sel = 2'd3;
        op_valid = 1'b1; op_code = 3'd5; dst_sel = 2'd0; src_sel = 2'd3;
        checkOutput("swap ready pre", 32'(op_ready), 32'd1);
        applyStimulus();
        checkOutput("swap1 ready", 32'(op_ready), 32'd0);
        checkOutput("swap1 r0", 32'(alu_a), 32'h22);
        checkOutput("swap1 r3", 32'(alu_b), 32'h22);
        applyStimulus();
        checkOutput("swap2 ready", 32'(op_ready), 32'd1);
        checkOutput("swap2 done", 32'(op_done), 32'd1);
        checkOutput("swap2 r0", 32'(alu_a), 32'h22);
        checkOutput("swap2 r3", 32'(alu_b), 32'h11);
        applyStimulus();
        op_valid = 1'b0;
        checkOutput("reswap done", 32'(op_done), 32'd0);
        applyStimulus();
        checkOutput("reswap r0", 32'(alu_a), 32'h11);
        checkOutput("reswap r3", 32'(alu_b), 32'h22);

        // Reset lands during SWAP2: the second write is lost and no done pulse appears.
        doOp(3'd5, 2'd0, 2'd3, 8'h00);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("rst swap r0", 32'(alu_a), 32'h00);
        checkOutput("rst swap r3", 32'(alu_b), 32'h00);
        checkOutput("rst swap ready", 32'(op_ready), 32'd1);
        checkOutput("rst swap done", 32'(op_done), 32'd0);
        applyStimulus();
        checkOutput("rst swap done2", 32'(op_done), 32'd0);

        // Bus drive and a load from the bus while driving it.
        a_sel = 2'd2;
        doOp(3'd1, 2'd2, 2'd0, 8'h3C);
        out_en = 1'b1; out_sel = 2'd2;
        #1;
        checkOutput("bus drive", 32'(bus_out), 32'h3C);
        checkOutput("bus drive flag", 32'(bus_drive), 32'd1);
        out_en = 1'b0;
        #1;
        checkOutput("bus idle", 32'(bus_out), 32'h00);
        checkOutput("bus idle flag", 32'(bus_drive), 32'd0);
        out_en = 1'b1;
        doOp(3'd1, 2'd2, 2'd0, 8'h81);
        checkOutput("bus reload", 32'(alu_a), 32'h81);
        checkOutput("bus reload out", 32'(bus_out), 32'h81);

        // Randomized traffic, with occasional resets, checked by the model.
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            op_valid = ($urandom_range(0, 99) < 60);
            op_code  = 3'($urandom_range(0, 7));
            dst_sel  = 2'($urandom_range(0, 3));
            src_sel  = 2'($urandom_range(0, 3));
            bus_in   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            out_en   = 1'($urandom_range(0, 1));
            out_sel  = 2'($urandom_range(0, 3));
            a_sel    = 2'($urandom_range(0, 3));
            b_sel    = 2'($urandom_range(0, 3));
            applyStimulus();
        end
        rst = 1'b0;
        op_valid = 1'b0;

        // 16-bit, 3-register bank: the missing register and the 16-bit wrap.
        applyStimulus();
        sRst = 1'b0;
        checkOutput("sweep ready", 32'(sReady), 32'd1);
        sASel = 2'd3;
        sValid = 1'b1; sCode = 3'd1; sDst = 2'd3; sBus = 16'h1234;
        applyStimulus();
        sValid = 1'b0;
        checkOutput("sweep oor done", 32'(sDone), 32'd1);
        checkOutput("sweep oor read", 32'(sAluA), 32'h0000);
        checkOutput("sweep oor zero", 32'(sZero), 32'd0);
        sASel = 2'd0;
        sValid = 1'b1; sCode = 3'd1; sDst = 2'd0; sBus = 16'hFFFF;
        applyStimulus();
        sCode = 3'd2;
        applyStimulus();
        sValid = 1'b0;
        checkOutput("sweep inc wrap", 32'(sAluA), 32'h0000);
        checkOutput("sweep inc carry", 32'(sCarry), 32'd1);
        checkOutput("sweep inc zero", 32'(sZero), 32'd1);
        sValid = 1'b1; sCode = 3'd4; sDst = 2'd3;
        applyStimulus();
        sValid = 1'b0;
        checkOutput("sweep oor flags", 32'(sCarry), 32'd1);
        checkOutput("sweep oor b", 32'(sAluB), 32'h0000);

        applyStimulus();
        applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
